// File: rtl/apu_reg_writer.sv
// APU register-write front end: decodes two-byte address/data frames from the
// serial receiver into the $4000-$400F register file and per-channel change toggles.
module apu_reg_writer #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rx_valid,
   input  logic [7:0]   rx_data,
   output logic [127:0] apu_regs,
   output logic [3:0]   reg_change,
   output logic         frame_error,
   output logic         write_strobe
);

   typedef enum logic {
      IDLE = 1'b0,
      DATA = 1'b1
   } state_t;

   localparam logic [15:0] LAST_WAIT = TIMEOUT_CYCLES - 16'd1;

   state_t      state;
   logic [3:0]  offset;
   logic [15:0] wait_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order in this block.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the register file is a flat vector of flops, not a RAM, so it
         // can and must be cleared by reset; consumers read it every cycle.
         apu_regs     <= '0;
         reg_change   <= '0;
         frame_error  <= 1'b0;
         write_strobe <= 1'b0;
         state        <= IDLE;
         offset       <= '0;
         wait_cnt     <= '0;
      end else begin
         frame_error  <= 1'b0;
         write_strobe <= 1'b0;
         case (state)
            IDLE: begin
               if (rx_valid) begin
                  if (rx_data[7:4] == 4'b1000) begin
                     offset   <= rx_data[3:0];
                     wait_cnt <= '0;
                     state    <= DATA;
                  end else begin
                     frame_error <= 1'b1;
                  end
               end
            end
            DATA: begin
               // A byte arriving on the timeout cycle still completes the frame.
               if (rx_valid) begin
                  apu_regs[{offset, 3'b000} +: 8] <= rx_data;
                  write_strobe <= 1'b1;
                  if (offset[1:0] == 2'b11)
                     reg_change[offset[3:2]] <= ~reg_change[offset[3:2]];
                  state <= IDLE;
               end else if (wait_cnt == LAST_WAIT) begin
                  frame_error <= 1'b1;
                  state       <= IDLE;
               end else if (wait_cnt != 16'hFFFF) begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apu_reg_writer.sv
// Self-checking bench for apu_reg_writer: directed frames followed by random
// byte streams, compared against a frame-level reference model.
module tb_apu_reg_writer;

   localparam int TO = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         rx_valid = 1'b0;
   logic [7:0]   rx_data = 8'h00;
   logic [127:0] apu_regs;
   logic [3:0]   reg_change;
   logic         frame_error;
   logic         write_strobe;

   int checks = 0;
   int errors = 0;

   // Reference model: frame-level view of the protocol.
   logic [7:0] m_regs [16];
   logic [3:0] m_tog;
   bit         m_pending;
   int         m_off;
   int         m_idle;
   bit         m_fe;
   bit         m_ws;

   apu_reg_writer #(.TIMEOUT_CYCLES(16'(TO))) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_valid     (rx_valid),
      .rx_data      (rx_data),
      .apu_regs     (apu_regs),
      .reg_change   (reg_change),
      .frame_error  (frame_error),
      .write_strobe (write_strobe)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] model_vec();
      logic [127:0] v;
      for (int i = 0; i < 16; i++) v[8*i +: 8] = m_regs[i];
      return v;
   endfunction

   task automatic model_update(input bit r, input bit v, input logic [7:0] d);
      m_fe = 0;
      m_ws = 0;
      if (r) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
         m_tog = 4'b0000;
         m_pending = 0;
         m_off = 0;
         m_idle = 0;
      end else if (!m_pending) begin
         if (v) begin
            if (d[7:4] == 4'h8) begin
               m_pending = 1;
               m_off = int'(d[3:0]);
               m_idle = 0;
            end else begin
               m_fe = 1;
            end
         end
      end else begin
         if (v) begin
            m_regs[m_off] = d;
            m_ws = 1;
            if (m_off % 4 == 3) m_tog[m_off / 4] = ~m_tog[m_off / 4];
            m_pending = 0;
         end else begin
            m_idle++;
            if (m_idle == TO) begin
               m_fe = 1;
               m_pending = 0;
            end
         end
      end
   endtask

   // Drive one cycle, advance the model, then compare outputs just after the edge.
   task automatic step(input bit v, input logic [7:0] d, input bit r);
      rx_valid = v;
      rx_data  = d;
      rst      = r;
      @(posedge clk);
      model_update(r, v, d);
      #1;
      check_val("apu_regs", apu_regs, model_vec());
      check_val("reg_change", 128'(reg_change), 128'(m_tog));
      check_val("frame_error", 128'(frame_error), 128'(m_fe));
      check_val("write_strobe", 128'(write_strobe), 128'(m_ws));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 8'h00, 0);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_regs[i] = 8'hFF;
      m_tog = 4'hF;
      m_pending = 0;
      m_off = 0;
      m_idle = 0;

      // Reset state
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);
      check_val("reset_regs", apu_regs, 128'h0);

      // Write $400C, no toggle
      step(1, 8'h8C, 0);
      step(1, 8'h3F, 0);
      check_val("reg_400c", 128'(apu_regs[103:96]), 128'h3F);
      check_val("ws_400c", 128'(write_strobe), 128'h1);
      idle(2);

      // $400F twice: toggle 0->1->0
      step(1, 8'h8F, 0);
      step(1, 8'h58, 0);
      check_val("toggle3_up", 128'(reg_change), 128'h8);
      idle(1);
      step(1, 8'h8F, 0);
      step(1, 8'h58, 0);
      check_val("toggle3_down", 128'(reg_change), 128'h0);
      check_val("reg_400f", 128'(apu_regs[127:120]), 128'h58);

      // Bad address byte, then back-to-back $4003 write
      step(1, 8'h42, 0);
      check_val("bad_addr_fe", 128'(frame_error), 128'h1);
      step(1, 8'h83, 0);
      step(1, 8'h11, 0);
      check_val("reg_4003", 128'(apu_regs[31:24]), 128'h11);
      check_val("toggle0", 128'(reg_change[0]), 128'h1);

      // Timeout: 8 idle cycles abandon the frame, then 0x77 is rejected
      step(1, 8'h8E, 0);
      idle(TO - 1);
      check_val("no_early_fe", 128'(frame_error), 128'h0);
      step(0, 8'h00, 0);
      check_val("timeout_fe", 128'(frame_error), 128'h1);
      step(1, 8'h77, 0);
      check_val("stray_data_fe", 128'(frame_error), 128'h1);
      check_val("reg_400e_clear", 128'(apu_regs[119:112]), 128'h0);

      // Data on the timeout cycle wins; address-format byte is data in DATA
      step(1, 8'h8E, 0);
      idle(TO - 1);
      step(1, 8'h81, 0);
      check_val("late_data", 128'(apu_regs[119:112]), 128'h81);
      check_val("late_fe", 128'(frame_error), 128'h0);

      // Reset mid-frame beats a simultaneous byte
      step(1, 8'h85, 0);
      step(1, 8'hAA, 1);
      check_val("rst_mid_frame", apu_regs, 128'h0);
      step(1, 8'hAA, 0);
      check_val("post_rst_fe", 128'(frame_error), 128'h1);

      // Random streams with gaps, address-biased bytes and rare resets
      for (int n = 0; n < 3000; n++) begin
         bit         r, v;
         logic [7:0] d;
         r = ($urandom_range(0, 299) == 0);
         v = ($urandom_range(0, 2) != 0);
         d = ($urandom_range(0, 1) == 0) ? {4'h8, 4'($urandom_range(0, 15))} : 8'($urandom);
         step(v, d, r);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
